fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 23 ++
 rtl/fetch_controller_if.sv | 31 +++
 rtl/fetch_pc_reg.sv | 41 ++++
 rtl/fetch_controller.sv | 94 +++++++++
 tb/tb_fetch_controller.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - fetch_state_e : controller FSM states (IDLE / RUN / HALT)
//   - ADDR_W_DEF    : default ROM word-address width
//   - HALT_WORD_DEF : instruction encoding that stops fetching
//   - NOP_WORD_DEF  : bubble placed in the IF/ID register (addi x0, x0, 0)
//   - sat_inc16     : 16-bit increment that sticks at all-ones
package fetch_controller_pkg;

    localparam int unsigned ADDR_W_DEF    = 5;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } fetch_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle: control from the pipeline, the external ROM port and
// the IF/ID register outputs.
//   master : the fetch controller (drives rom_addr and the out_* / status signals)
//   slave  : the surrounding pipeline / ROM (drives start, stall, redirect, rom_instr)
interface fetch_controller_if
    import fetch_controller_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              halted;
    logic [15:0]       fetch_count;

    modport master (
        input  start, stall, redirect_valid, redirect_addr, rom_instr,
        output rom_addr, out_valid, out_instr, out_pc, halted, fetch_count
    );

    modport slave (
        output start, stall, redirect_valid, redirect_addr, rom_instr,
        input  rom_addr, out_valid, out_instr, out_pc, halted, fetch_count
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program-counter register. Load has priority over increment; the
// increment wraps naturally modulo 2^ADDR_W; with neither asserted it holds.
//   clk, rst_n   : clock, synchronous active-low reset (pc -> 0)
//   load_i       : load load_addr_i
//   load_addr_i  : new pc value
//   inc_i        : advance pc by one word
//   pc_o         : current pc
module fetch_pc_reg
    import fetch_controller_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch controller: walks a combinational external ROM and
// fills a registered IF/ID stage, handling stall, redirect and halt.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch_controller_if.master (start/stall/redirect in,
//                rom_addr/rom_instr ROM port, out_valid/out_instr/out_pc,
//                halted, fetch_count out)
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_controller_if.master bus
);
    fetch_state_e      state_q;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic              halted_q;
    logic [15:0]       count_q;
    logic [ADDR_W-1:0] pc;

    // Redirect outranks stall, and stall outranks halt detection, so the
    // halt word only takes effect once the stage is free to advance.
    logic in_run, do_redirect, advance, halt_seen, deliver;

    always_comb begin
        in_run      = (state_q == ST_RUN);
        do_redirect = in_run && bus.redirect_valid;
        advance     = in_run && !bus.redirect_valid && !bus.stall;
        halt_seen   = advance && (bus.rom_instr == HALT_WORD);
        deliver     = advance && (bus.rom_instr != HALT_WORD);
    end

    fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (do_redirect),
        .load_addr_i (bus.redirect_addr),
        .inc_i       (deliver),
        .pc_o        (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_WORD;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (do_redirect) begin
                        out_valid_q <= 1'b0;
                        out_instr_q <= NOP_WORD;
                    end else if (halt_seen) begin
                        state_q     <= ST_HALT;
                        halted_q    <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_instr_q <= NOP_WORD;
                    end else if (deliver) begin
                        out_valid_q <= 1'b1;
                        out_instr_q <= bus.rom_instr;
                        out_pc_q    <= pc;
                        count_q     <= sat_inc16(count_q);
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr    = pc;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    localparam int unsigned AW   = 5;
    localparam int          NROM = 32;
    localparam logic [31:0] NOP  = NOP_WORD_DEF;
    localparam logic [31:0] HLT  = HALT_WORD_DEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_controller_if #(.ADDR_W(AW)) bus ();
    logic [31:0] rom [NROM];
    assign bus.rom_instr = rom[bus.rom_addr];

    fetch_controller #(.ADDR_W(AW), .HALT_WORD(HLT), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (abstract fetch behaviour) ----------
    // mode: 0 = waiting for start, 1 = fetching, 2 = stopped
    int          m_mode, m_pc, m_opc, m_cnt;
    bit          m_valid;
    logic [31:0] m_instr;

    task automatic model_step(input bit r, input bit s, input bit st, input bit rv, input int ra);
        logic [31:0] w;
        if (!r) begin
            m_mode = 0; m_pc = 0; m_opc = 0; m_cnt = 0; m_valid = 0; m_instr = NOP;
        end else if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (rv) begin
                m_pc = ra; m_valid = 0; m_instr = NOP;
            end else if (!st) begin
                w = rom[m_pc];
                if (w == HLT) begin
                    m_mode = 2; m_valid = 0; m_instr = NOP;
                end else begin
                    m_instr = w; m_opc = m_pc; m_valid = 1;
                    m_pc  = (m_pc + 1) % NROM;
                    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit st, input bit rv, input int ra);
        rst_n              = r;
        bus.start          = s;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_addr  = AW'(ra);
        model_step(r, s, st, rv, ra);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rom_addr"},    32'(bus.rom_addr),    32'(m_pc));
        chk({tag, ".out_valid"},   32'(bus.out_valid),   32'(m_valid));
        chk({tag, ".out_instr"},   bus.out_instr,        m_instr);
        chk({tag, ".out_pc"},      32'(bus.out_pc),      32'(m_opc));
        chk({tag, ".halted"},      32'(bus.halted),      32'(m_mode == 2));
        chk({tag, ".fetch_count"}, 32'(bus.fetch_count), 32'(m_cnt));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r, s, st, rv;
        int          ra;
        bit          v;
        int          opc;
        logic [31:0] instr;
        bit          h;
        int          cnt;
        int          raddr;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit st, bit rv, int ra,
                                bit v, int opc, logic [31:0] instr, bit h, int cnt, int raddr);
        vec_t x;
        x.r = r; x.s = s; x.st = st; x.rv = rv; x.ra = ra;
        x.v = v; x.opc = opc; x.instr = instr; x.h = h; x.cnt = cnt; x.raddr = raddr;
        return x;
    endfunction

    vec_t vecs [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_addr = '0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Program run, halt, ignored inputs in HALT, reset-over-start, stall hold.
        for (int i = 0; i < NROM; i++) rom[i] = NOP;
        rom[0] = 32'h0080_0293; rom[1] = 32'h00F0_0313; rom[2] = HLT;
        //            r     s     st    rv    ra  | v     opc instr          h     cnt raddr
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0,   1'b0, 0, NOP,           1'b0, 0, 0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 0,   1'b0, 0, NOP,           1'b0, 0, 0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 0, 32'h0080_0293, 1'b0, 1, 1);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 1, 32'h00F0_0313, 1'b0, 2, 2);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b0, 1, NOP,           1'b1, 2, 2);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 7,   1'b0, 1, NOP,           1'b1, 2, 2);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,   1'b0, 0, NOP,           1'b0, 0, 0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 0,   1'b0, 0, NOP,           1'b0, 0, 0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 0, 32'h0080_0293, 1'b0, 1, 1);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 0,   1'b1, 0, 32'h0080_0293, 1'b0, 1, 1);
        vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 0,   1'b1, 0, 32'h0080_0293, 1'b0, 1, 1);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 0,   1'b1, 0, 32'h0080_0293, 1'b0, 1, 1);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 1, 32'h00F0_0313, 1'b0, 2, 2);

        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].r, vecs[i].s, vecs[i].st, vecs[i].rv, vecs[i].ra);
            chk($sformatf("vec%0d.out_valid", i),   32'(bus.out_valid),   32'(vecs[i].v));
            chk($sformatf("vec%0d.out_pc", i),      32'(bus.out_pc),      32'(vecs[i].opc));
            chk($sformatf("vec%0d.out_instr", i),   bus.out_instr,        vecs[i].instr);
            chk($sformatf("vec%0d.halted", i),      32'(bus.halted),      32'(vecs[i].h));
            chk($sformatf("vec%0d.fetch_count", i), 32'(bus.fetch_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d.rom_addr", i),    32'(bus.rom_addr),    32'(vecs[i].raddr));
        end

        // Redirect to 20 while stalled at pc 5.
        for (int i = 0; i < NROM; i++) rom[i] = 32'h1000_0000 + 32'(i);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("redir.pc_before", 32'(bus.rom_addr), 32'd5);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 20);
        chk("redir.bubble_valid", 32'(bus.out_valid), 32'd0);
        chk("redir.bubble_instr", bus.out_instr, NOP);
        chk("redir.new_pc", 32'(bus.rom_addr), 32'd20);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("redir.valid", 32'(bus.out_valid), 32'd1);
        chk("redir.out_pc", 32'(bus.out_pc), 32'd20);
        chk("redir.out_instr", bus.out_instr, 32'h1000_0014);

        // Halt word at pc 4 with a redirect to 8 in the same cycle.
        rom[4] = HLT;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("haltredir.pc_before", 32'(bus.rom_addr), 32'd4);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8);
        chk("haltredir.not_halted", 32'(bus.halted), 32'd0);
        chk("haltredir.bubble", 32'(bus.out_valid), 32'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("haltredir.out_pc", 32'(bus.out_pc), 32'd8);
        chk("haltredir.out_instr", bus.out_instr, 32'h1000_0008);
        chk("haltredir.valid", 32'(bus.out_valid), 32'd1);

        // Reset during a stalled RUN.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("rststall.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rststall.fetch_count", 32'(bus.fetch_count), 32'd0);
        chk("rststall.rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rststall.out_instr", bus.out_instr, NOP);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("rststall.idle_valid", 32'(bus.out_valid), 32'd0);
        chk("rststall.idle_pc", 32'(bus.rom_addr), 32'd0);

        // All-NOP ROM: pc wraps 31 -> 0.
        for (int i = 0; i < NROM; i++) rom[i] = NOP;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 33; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
            chk($sformatf("wrap.out_pc%0d", k), 32'(bus.out_pc), 32'(k % NROM));
        end
        chk("wrap.fetch_count", 32'(bus.fetch_count), 32'd33);

        // Randomized run against the reference model.
        for (int i = 0; i < NROM; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? HLT : $urandom;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk_model("rnd_init");
        for (int c = 0; c < 3000; c++) begin
            bit r, s, st, rv;
            int ra;
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 9) == 0);
            ra = int'($urandom_range(0, NROM - 1));
            tick(r, s, st, rv, ra);
            chk_model($sformatf("rnd%0d", c));
            if (!r && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < NROM; i++)
                    rom[i] = ($urandom_range(0, 15) == 0) ? HLT : $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
